// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding and hold-counter sizing for the imem boot loader
package boot_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } boot_state_t;

    localparam int HOLD_W           = 8;
    localparam int RST_HOLD_DEFAULT = 4;

endpackage

// File: rtl/boot_checksum.sv
// rtl/boot_checksum.sv - 32-bit wrap-around accumulator of program words with compare against a trailer beat
module boot_checksum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              acc,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] check,
    output logic              match
);

    logic [31:0] sum;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (acc) begin
            sum <= sum + 32'(data);
        end
    end

    assign match = (sum == 32'(check));

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a program image into imem and holds the core in reset until loaded; BOOT_CHECKSUM_EN adds a trailer checksum
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int RST_HOLD = RST_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   WC_ONE    = 1;
    localparam logic [HOLD_W-1:0] HOLD_ONE  = 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    boot_state_t       state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              transfer;
    logic              write_beat;
    logic              overflow;

    assign transfer = s_valid && s_ready;
    assign overflow = (word_count == DEPTH_CNT);

`ifdef BOOT_CHECKSUM_EN
    // The s_last beat carries the checksum of the preceding words and is never written.
    logic cks_match;
    logic reload_take;

    assign write_beat  = transfer && !s_last;
    assign reload_take = reload && (state == ST_RUN || state == ST_ERR);

    boot_checksum #(
        .DATA_W(DATA_W)
    ) u_checksum (
        .clk  (clk),
        .rst  (rst),
        .clear(reload_take),
        .acc  (write_beat && !overflow),
        .data (s_data),
        .check(s_data),
        .match(cks_match)
    );
`else
    assign write_beat = transfer;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            hold_cnt   <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_LOAD: begin
                    s_ready <= 1'b1;
                    if (write_beat && overflow) begin
                        state   <= ST_ERR;
                        s_ready <= 1'b0;
                        err     <= 1'b1;
                    end else if (transfer) begin
                        if (write_beat) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_count[ADDR_W-1:0];
                            imem_wdata <= s_data;
                            word_count <= word_count + WC_ONE;
                        end
                        if (s_last) begin
                            s_ready  <= 1'b0;
                            hold_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
                            if (cks_match) begin
                                state <= ST_HOLD;
                            end else begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end
`else
                            state <= ST_HOLD;
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    // HOLD lasts exactly RST_HOLD cycles, the first being the final write.
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_RUN;
                        core_rst <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                ST_RUN, ST_ERR: begin
                    if (reload) begin
                        state      <= ST_LOAD;
                        s_ready    <= 1'b1;
                        core_rst   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        imem_addr  <= '0;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed bench with a phase-level reference model for imem_boot_loader
module tb_imem_boot_loader;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int HOLD  = 4;
    localparam int DEPTH = 1 << AW;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          core_rst;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    always #5 clk = ~clk;

    imem_boot_loader #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RST_HOLD(HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .reload    (reload),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .err       (err),
        .word_count(word_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase of the boot the image is in, how many words landed, hold time left.
    typedef enum {M_LOAD, M_HOLD, M_RUN, M_ERR} mphase_t;
    mphase_t       ph;
    int            left;
    int            words;
    logic [31:0]   sum;
    logic          e_ready, e_we, e_core_rst, e_done, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            e_wc;

    initial forever begin
        bit xfer, wr;
        @(posedge clk);
        xfer = s_valid && e_ready;
        wr   = xfer && !(CKS && s_last);
        e_we = 1'b0;
        if (rst) begin
            ph = M_LOAD; words = 0; sum = '0; e_addr = '0; e_wdata = '0;
        end else begin
            case (ph)
                M_LOAD: begin
                    if (wr && words == DEPTH) begin
                        ph = M_ERR;
                    end else begin
                        if (wr) begin
                            e_we = 1'b1; e_addr = AW'(words); e_wdata = s_data;
                            words++; sum = sum + s_data;
                        end
                        if (xfer && s_last) begin
                            ph   = (!CKS || sum == s_data) ? M_HOLD : M_ERR;
                            left = HOLD;
                        end
                    end
                end
                M_HOLD: begin
                    left--;
                    if (left == 0) ph = M_RUN;
                end
                default: begin
                    if (reload) begin
                        ph = M_LOAD; words = 0; sum = '0; e_addr = '0;
                    end
                end
            endcase
        end
        e_ready    = (ph == M_LOAD) && !rst;
        e_core_rst = (ph != M_RUN);
        e_done     = (ph == M_RUN);
        e_err      = (ph == M_ERR);
        e_wc       = words;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (check_en) begin
            chk("s_ready", s_ready, e_ready);
            chk("imem_we", imem_we, e_we);
            chk("imem_addr", imem_addr, e_addr);
            chk("imem_wdata", imem_wdata, e_wdata);
            chk("core_rst", core_rst, e_core_rst);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("word_count", word_count, e_wc);
        end
    end

    logic [AW-1:0] wlog_addr[$];
    logic [DW-1:0] wlog_data[$];
    int            cyc = 0;
    int            last_we_cyc = 0;
    int            fall_cyc = 0;
    logic          prev_core_rst = 1'b1;

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (imem_we) begin
            wlog_addr.push_back(imem_addr);
            wlog_data.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (prev_core_rst && !core_rst) fall_cyc = cyc;
        prev_core_rst = core_rst;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, input int gap);
        int  n   = 0;
        bit  acc = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = last;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #2;
            n++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!acc) chk("handshake_timeout", 64'd0, 64'd1);
        if (gap > 0) step(gap);
    endtask

    task automatic reload_pulse();
        reload = 1'b1;
        step(1);
        reload = 1'b0;
    endtask

    logic [DW-1:0] img[3] = '{32'h0010_0093, 32'h0020_0113, 32'h0020_81B3};

    task automatic check_image(input string tag);
        chk({tag, "_nwrites"}, wlog_addr.size(), 3);
        for (int i = 0; i < 3 && i < wlog_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wlog_addr[i], i);
            chk($sformatf("%s_data%0d", tag, i), wlog_data[i], img[i]);
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: bench did not reach its end");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; reload = 1'b0;
        step(2);
        check_en = 1'b1;
        step(1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_word_count", word_count, 0);
        rst = 1'b0;
        step(1);

`ifndef BOOT_CHECKSUM_EN
        // 1: back-to-back image
        wlog_addr.delete(); wlog_data.delete();
        for (int i = 0; i < 3; i++) send_word(img[i], i == 2, 0);
        step(5);
        check_image("t1");
        chk("t1_release_delay", fall_cyc - last_we_cyc, 4);
        chk("t1_done", done, 1);
        chk("t1_word_count", word_count, 3);

        // 2: same image with one idle cycle between beats
        reload_pulse();
        wlog_addr.delete(); wlog_data.delete();
        for (int i = 0; i < 3; i++) send_word(img[i], i == 2, 1);
        step(5);
        check_image("t2");
        chk("t2_done", done, 1);

        // 3: overflow on the fifth word into a 4-word memory
        reload_pulse();
        wlog_addr.delete(); wlog_data.delete();
        for (int i = 0; i < 5; i++) send_word(32'h100 + i, 1'b0, 0);
        chk("t3_err", err, 1);
        chk("t3_core_rst", core_rst, 1);
        chk("t3_word_count", word_count, 4);
        chk("t3_nwrites", wlog_addr.size(), 4);
        step(2);
        chk("t3_err_sticky", err, 1);
        reload_pulse();
        chk("t3_reload_err", err, 0);
        chk("t3_reload_wc", word_count, 0);
        chk("t3_reload_ready", s_ready, 1);

        // 4: reset mid-load, then a one-word image
        send_word(32'hA0, 1'b0, 0);
        send_word(32'hA1, 1'b0, 0);
        rst = 1'b1;
        step(1);
        chk("t4_s_ready", s_ready, 0);
        chk("t4_imem_we", imem_we, 0);
        chk("t4_imem_addr", imem_addr, 0);
        chk("t4_imem_wdata", imem_wdata, 0);
        chk("t4_core_rst", core_rst, 1);
        chk("t4_done", done, 0);
        chk("t4_err", err, 0);
        chk("t4_word_count", word_count, 0);
        rst = 1'b0;
        wlog_addr.delete(); wlog_data.delete();
        send_word(32'h0000_0013, 1'b1, 0);
        step(5);
        chk("t4_done_after", done, 1);
        chk("t4_nwrites", wlog_addr.size(), 1);
        if (wlog_addr.size() > 0) begin
            chk("t4_addr", wlog_addr[0], 0);
            chk("t4_data", wlog_data[0], 32'h0000_0013);
        end

        // 6: reload ignored in LOAD and HOLD, honoured in RUN
        reload_pulse();
        reload_pulse();
        chk("t6_load_ready", s_ready, 1);
        wlog_addr.delete(); wlog_data.delete();
        send_word(32'hAAAA_0001, 1'b0, 0);
        reload_pulse();
        chk("t6_load_wc", word_count, 1);
        send_word(32'hAAAA_0002, 1'b1, 0);
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        reload_pulse();
        step(1);
        s_valid = 1'b0;
        chk("t6_hold_done", done, 0);
        chk("t6_hold_core_rst", core_rst, 1);
        step(3);
        chk("t6_run_done", done, 1);
        chk("t6_nwrites", wlog_addr.size(), 2);
        reload_pulse();
        chk("t6_reload_core_rst", core_rst, 1);
        chk("t6_reload_done", done, 0);

        // 7: exactly DEPTH words with s_last on the last one is legal
        wlog_addr.delete(); wlog_data.delete();
        for (int i = 0; i < DEPTH; i++) send_word(32'h11 * (i + 1), i == DEPTH - 1, 0);
        step(5);
        chk("t7_done", done, 1);
        chk("t7_err", err, 0);
        chk("t7_word_count", word_count, DEPTH);
        chk("t7_nwrites", wlog_addr.size(), DEPTH);
`else
        // 5: checksum trailer, match then mismatch
        wlog_addr.delete(); wlog_data.delete();
        send_word(32'h1, 1'b0, 0);
        send_word(32'h2, 1'b0, 0);
        send_word(32'h3, 1'b1, 0);
        step(5);
        chk("t5_done", done, 1);
        chk("t5_word_count", word_count, 2);
        chk("t5_nwrites", wlog_addr.size(), 2);
        reload_pulse();
        send_word(32'h1, 1'b0, 0);
        send_word(32'h2, 1'b0, 0);
        send_word(32'h4, 1'b1, 0);
        step(1);
        chk("t5_bad_err", err, 1);
        chk("t5_bad_core_rst", core_rst, 1);
        chk("t5_bad_done", done, 0);
`endif

        step(2);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
